// File: rtl/alu_disp_pkg.sv
// Shared constants for the ALU result display: segment patterns and FSM state type.
// Segment patterns are active-low, segment a on bit 0 through g on bit 6.
package alu_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Entry N is the glyph for hex digit N: 0-9, A, b, C, d, E, F
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } disp_state_t;

    function automatic logic [3:0] digit_an(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph.
// Zero latency; no flow control.
module seg7_hex_decoder
    import alu_disp_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[hex];

endmodule

// File: rtl/alu_display_ctrl.sv
// Multiplexed 4-digit display of captured ALU value and opcode; seg/an registered, 1 cycle latency.
// No backpressure: load is a strobe. Define ALU_DISP_LZB_EN to blank a zero upper value nibble.
module alu_display_ctrl
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] value,
    input  logic [3:0] op,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic [1:0]       idx;
    disp_state_t      state;
    disp_state_t      state_next;
    logic [7:0]       value_q;
    logic [3:0]       op_q;
    logic [3:0]       nibble;
    logic [6:0]       hex_seg;
    logic [6:0]       seg_next;
    logic             lzb_digit1;

    assign tc = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else begin
            cnt <= tc ? '0 : cnt + 1'b1;
            if (tc) begin
                idx <= idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 8'h00;
            op_q    <= 4'h0;
        end else if (load) begin
            value_q <= value;
            op_q    <= op;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BLANK;
        end else begin
            state <= state_next;
        end
    end

`ifdef ALU_DISP_LZB_EN
    assign lzb_digit1 = (value_q[7:4] == 4'h0);
`else
    assign lzb_digit1 = 1'b0;
`endif

    // Single decoder shared by all digits; digit 2 never shows a glyph.
    always_comb begin
        nibble = op_q;
        case (idx)
            2'd0:    nibble = value_q[3:0];
            2'd1:    nibble = value_q[7:4];
            default: nibble = op_q;
        endcase
    end

    seg7_hex_decoder u_dec (
        .hex (nibble),
        .seg (hex_seg)
    );

    always_comb begin
        state_next = state;
        seg_next   = SEG_DASH;
        case (state)
            BLANK: begin
                if (load) begin
                    state_next = SHOW;
                end
                seg_next = SEG_DASH;
            end
            SHOW: begin
                if (idx == 2'd2) begin
                    seg_next = SEG_BLANK;
                end else if (idx == 2'd1 && lzb_digit1) begin
                    seg_next = SEG_BLANK;
                end else begin
                    seg_next = hex_seg;
                end
            end
            default: begin
                state_next = BLANK;
                seg_next   = SEG_DASH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= 4'b1111;
        end else begin
            seg <= seg_next;
            an  <= digit_an(idx);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_alu_display_ctrl.sv
// Scoreboard bench for alu_display_ctrl with REFRESH_DIV=4 using directed vectors.
module tb_alu_display_ctrl;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] value;
    logic [3:0] op;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    alu_display_ctrl #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .value (value),
        .op    (op),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    // Display sets, digit 0 in the lowest slot
    localparam logic [3:0][6:0] DASHES = {4{7'b0111111}};
    localparam logic [3:0][6:0] D_3A1  = {7'b1111001, 7'b1111111, 7'b0110000, 7'b0001000};
`ifdef ALU_DISP_LZB_EN
    localparam logic [6:0]      D1_05  = 7'b1111111;
`else
    localparam logic [6:0]      D1_05  = 7'b1000000;
`endif
    localparam logic [3:0][6:0] D_05C  = {7'b1000110, 7'b1111111, D1_05, 7'b0010010};
    localparam logic [3:0][6:0] D_FFE  = {7'b0000110, 7'b1111111, 7'b0001110, 7'b0001110};
    localparam logic [3:0][6:0] D_122  = {7'b0100100, 7'b1111111, 7'b1111001, 7'b0100100};
    localparam logic [3:0][6:0] D_343  = {7'b0110000, 7'b1111111, 7'b0110000, 7'b0011001};
    localparam logic [3:0][6:0] D_C79  = {7'b0010000, 7'b1111111, 7'b1000110, 7'b1111000};
    localparam logic [3:0][3:0] ANS    = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    obs_t            exp_q[$];
    int              checks = 0;
    int              errors = 0;
    int              phase  = 0;
    string           tag    = "reset";
    logic [3:0][6:0] cur_disp = DASHES;

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp} !== e) begin
                errors++;
                $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                         tag, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    end

    // One clock: apply inputs, then predict what the edge leaves on the outputs.
    task automatic tick(input logic r, input logic ld, input logic [7:0] v,
                        input logic [3:0] o, input logic [3:0][6:0] nd);
        int slot;
        reset = r;
        load  = ld;
        value = v;
        op    = o;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.push_back(obs_t'{4'b1111, 7'b1111111, 1'b1});
            phase    = 0;
            cur_disp = DASHES;
        end else begin
            slot = phase / 4;
            exp_q.push_back(obs_t'{ANS[slot], cur_disp[slot], 1'b1});
            phase = (phase + 1) % 16;
            if (ld) begin
                cur_disp = nd;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b0, 1'b0, 8'(i * 37 + 5), 4'(i * 3 + 1), DASHES);
        end
    endtask

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = 8'h00;
        op    = 4'h0;

        tag = "reset_hold";
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00, 4'h0, DASHES);

        tag = "blank_scan";
        idle(16);

        tag = "load_3A_1";
        tick(1'b0, 1'b1, 8'h3A, 4'h1, D_3A1);
        idle(16);

        tag = "load_05_C";
        tick(1'b0, 1'b1, 8'h05, 4'hC, D_05C);
        idle(20);

        tag = "load_on_tc";
        while (phase != 3) idle(1);
        tick(1'b0, 1'b1, 8'hFF, 4'hE, D_FFE);
        idle(8);

        tag = "load_held";
        tick(1'b0, 1'b1, 8'h12, 4'h2, D_122);
        tick(1'b0, 1'b1, 8'h34, 4'h3, D_343);
        tick(1'b0, 1'b1, 8'hC7, 4'h9, D_C79);

        tag = "long_run";
        idle(64);

        tag = "reset_mid_scan";
        while (phase != 10) idle(1);
        tick(1'b1, 1'b1, 8'h77, 4'h7, D_3A1);
        tick(1'b1, 1'b1, 8'h77, 4'h7, D_3A1);
        tag = "post_reset_blank";
        idle(16);

        tag = "reload";
        tick(1'b0, 1'b1, 8'h3A, 4'h1, D_3A1);
        idle(16);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_display_ctrl.md
ALU_DISPLAY_CTRL -- requirements
Module: alu_display_ctrl

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load  input  1  single-cycle strobe; capture value and op.
REQ-005 Port: value  input  8  ALU Y result to display.
REQ-006 Port: op  input  4  operation code (sw[3:0]) to display.
REQ-007 Port: seg  output  7  segments a..g on seg[0]..seg[6], active-low.
REQ-008 Port: an  output  4  digit anodes, active-low, one-hot-low when driven.
REQ-009 Port: dp  output  1  decimal point, active-low; held 1 (off) at all times.

Function
REQ-010 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; terminal count (TC) is the cycle at REFRESH_DIV-1.
REQ-011 2-bit digit index SHALL advance 0->1->2->3->0 on each TC, wrapping from 3 to 0.
REQ-012 seg and an SHALL be registered, reflecting the digit index and display data with exactly 1 cycle latency.
REQ-013 an SHALL be 1110/1101/1011/0111 for index 0/1/2/3.
REQ-014 FSM states: BLANK (after reset, no data yet) and SHOW; BLANK->SHOW on first load; SHOW has no exit except reset.
REQ-015 In BLANK all four digits SHALL display dash (seg=7'b0111111).
REQ-016 In SHOW: digit0=hex(value_q[3:0]), digit1=hex(value_q[7:4]), digit2=blank (7'b1111111), digit3=hex(op_q).
REQ-017 Hex encoding SHALL be standard 0-9, A, b, C, d, E, F (e.g. 0=7'b1000000, 1=7'b1111001, 3=7'b0110000, A=7'b0001000).
REQ-018 On load, value_q/op_q SHALL update on the same edge; the new data appears on seg one cycle later for whichever digit is active.
REQ-019 load coincident with TC: both SHALL take effect; next slot shows new data.
REQ-020 load held high for multiple cycles: recapture every cycle; last captured wins.
REQ-021 Inputs value/op SHALL be ignored when load is low.

Reset
REQ-022 On reset: counter=0, index=0, state=BLANK, value_q=0, op_q=0, seg=7'b1111111, an=4'b1111, dp=1.
REQ-023 Reset SHALL override load and TC in the same cycle; reset mid-scan restarts at digit0 with a full REFRESH_DIV slot.
REQ-024 First cycle after reset release SHALL drive an=1110 with dash.

Configuration
REQ-025 Macro ALU_DISP_LZB_EN defined: in SHOW, digit1 SHALL be blank when value_q[7:4]==0.
REQ-026 Macro ALU_DISP_LZB_EN undefined: digit1 SHALL always show hex(value_q[7:4]), including '0'.

Structure
REQ-027 Package alu_disp_pkg SHALL hold SEG_BLANK, SEG_DASH, the 16-entry hex segment constants, and the FSM state typedef.
REQ-028 Combinational sub-module seg7_hex_decoder (4-bit in, 7-bit active-low out) SHALL be instantiated once on the muxed nibble.

Verification (REFRESH_DIV=4)
REQ-029 Reset 3 cycles, release -> seg=7F/an=F during reset; then an 1110,1101,1011,0111 each 4 cycles, all dash.
REQ-030 load with value=8'h3A, op=4'h1 -> an0 seg=0001000, an1 seg=0110000, an2 seg=1111111, an3 seg=1111001.
REQ-031 load value=8'h05 -> digit1 blank with ALU_DISP_LZB_EN, seg=1000000 without.
REQ-032 load value=8'hFF on TC cycle (index 0->1) -> next slot an=1101, seg=hex F=0001110.
REQ-033 Reset asserted 2 cycles into digit2 with SHOW active -> seg=7F/an=F, then BLANK dashes from digit0 with a full 4-cycle slot.
REQ-034 Run 64 cycles without load after SHOW -> index wraps 3->0 exactly every 16 cycles, data stable.
